// File: rtl/fifolifo_driver.sv
// Stimulus generator for the write/read side of a FIFO/LIFO under test.
// Define FIFOLIFO_DRV_ERRCHK_EN to enable the sticky flag-mismatch checker on err.

module fifolifo_driver #(
    parameter int          DEPTH     = 64,
    parameter int          dat_width = 32,
    parameter logic [31:0] SEED      = 32'hACE10001
) (
    input  logic                   CLK,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [15:0]            op_count,
    input  logic [1:0]             seq_sel,
    input  logic                   Full,
    input  logic                   Empty,
    output logic                   Wren,
    output logic                   Rden,
    output logic [dat_width-1:0]   data_in,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            ops_issued,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int          LW      = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [31:0] TAPS    = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_lfsr;
    logic [dat_width-1:0]  r_data;
    logic                  r_wren;
    logic                  r_rden;
    logic [LW-1:0]         r_level;
    logic [15:0]           r_ops;
    logic [15:0]           r_cnt;
    logic [1:0]            r_seq;
    logic                  r_dir;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_dir_nxt;
    logic [LW-1:0]         w_level_nxt;
    logic [15:0]           w_ops_inc;
    logic [31:0]           w_lfsr_nxt;
    logic                  w_launch;

    assign w_wr_ok    = (r_level < DEPTH_L) && !Full;
    assign w_rd_ok    = (r_level != '0) && !Empty;
    assign w_ops_inc  = (r_ops == 16'hFFFF) ? r_ops : r_ops + 16'd1;
    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_launch   = (r_state == S_IDLE) && start;

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_dir: fill-drain direction (1 = draining) or alternating toggle (1 = read next)
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_dir_nxt   = r_dir;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (op_count == 16'd0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                unique case (r_seq)
                    2'b00: begin
                        if (r_dir) begin
                            w_dir_nxt = (r_level != '0);
                        end else begin
                            w_dir_nxt = (r_level == DEPTH_L);
                        end
                        w_wr = !w_dir_nxt && w_wr_ok;
                        w_rd = w_dir_nxt && w_rd_ok;
                    end
                    2'b01: begin
                        if (r_dir) begin
                            w_rd = w_rd_ok;
                        end else begin
                            w_wr = w_wr_ok;
                        end
                        if (w_wr || w_rd) begin
                            w_dir_nxt = !r_dir;
                        end
                    end
                    2'b10: begin
                        if (r_lfsr[0]) begin
                            w_wr = w_wr_ok;
                            w_rd = !w_wr_ok && w_rd_ok;
                        end else begin
                            w_rd = w_rd_ok;
                            w_wr = !w_rd_ok && w_wr_ok;
                        end
                    end
                    2'b11: begin
                        w_wr = w_wr_ok;
                        w_rd = w_rd_ok;
                    end
                endcase
                if ((w_wr || w_rd) && (w_ops_inc == r_cnt)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_level == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_rd = w_rd_ok;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_rd) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_rd && !w_wr) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_lfsr  <= SEED;
            r_data  <= '0;
            r_wren  <= 1'b0;
            r_rden  <= 1'b0;
            r_level <= '0;
            r_ops   <= '0;
            r_cnt   <= '0;
            r_seq   <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wren  <= w_wr;
            r_rden  <= w_rd;
            r_level <= w_level_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_wr) begin
                r_data <= r_lfsr[dat_width-1:0];
                r_lfsr <= w_lfsr_nxt;
            end
            if (w_launch) begin
                r_cnt <= op_count;
                r_seq <= seq_sel;
                r_ops <= '0;
                r_dir <= 1'b0;
            end else begin
                r_dir <= w_dir_nxt;
                if ((r_state == S_RUN) && (w_wr || w_rd)) begin
                    r_ops <= w_ops_inc;
                end
            end
        end
    end

`ifdef FIFOLIFO_DRV_ERRCHK_EN
    logic [LW-1:0] r_lvl_d;
    logic          r_err;
    logic          w_mismatch;

    // Empty is only trusted once level has been stable for a cycle
    assign w_mismatch = (Full && (r_level < DEPTH_L))
                     || ((r_level == r_lvl_d) && (Empty != (r_level == '0)));

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_lvl_d <= '0;
            r_err   <= 1'b0;
        end else begin
            r_lvl_d <= r_level;
            if (r_busy && w_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign Wren       = r_wren;
    assign Rden       = r_rden;
    assign data_in    = r_data;
    assign level      = r_level;
    assign ops_issued = r_ops;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_fifolifo_driver.sv
// Directed bench for fifolifo_driver: a small DUT occupancy model drives the flags,
// and a scoreboard queue holds the expected write data.

module tb_fifolifo_driver;

    localparam int          DEPTH = 64;
    localparam int          DW    = 20;
    localparam int          LW    = 7;
    localparam logic [31:0] SEED  = 32'hACE10001;
`ifdef FIFOLIFO_DRV_ERRCHK_EN
    localparam logic        ERR_EXP = 1'b1;
`else
    localparam logic        ERR_EXP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          Rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   op_count = '0;
    logic [1:0]    seq_sel = '0;
    logic          force_full = 1'b0;
    logic          Full;
    logic          Empty;
    logic          Wren;
    logic          Rden;
    logic [DW-1:0] data_in;
    logic [LW-1:0] level;
    logic [15:0]   ops_issued;
    logic          busy;
    logic          done;
    logic          err;

    int            checks = 0;
    int            errors = 0;
    int            mdl_cnt;
    int            occ_after;
    logic [31:0]   m_lfsr = SEED;
    logic [31:0]   seed_v = SEED;
    logic [DW-1:0] exp_dq[$];
    logic [1:0]    log_q[$];
    logic [1:0]    exp_q[$];
    int            lmax;
    logic [15:0]   d_ops;
    logic [LW-1:0] d_lvl;
    logic [15:0]   cap_ops;

    fifolifo_driver #(
        .DEPTH(DEPTH),
        .dat_width(DW),
        .SEED(SEED)
    ) dut (
        .CLK(CLK),
        .Rst(Rst),
        .start(start),
        .op_count(op_count),
        .seq_sel(seq_sel),
        .Full(Full),
        .Empty(Empty),
        .Wren(Wren),
        .Rden(Rden),
        .data_in(data_in),
        .level(level),
        .ops_issued(ops_issued),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 CLK = ~CLK;

    // Flags of the modelled DUT already account for the strobes being presented
    always @(posedge CLK or posedge Rst) begin
        if (Rst) mdl_cnt <= 0;
        else     mdl_cnt <= mdl_cnt + int'(Wren) - int'(Rden);
    end

    assign occ_after = mdl_cnt + int'(Wren) - int'(Rden);
    assign Full      = force_full || (occ_after >= DEPTH);
    assign Empty     = (occ_after <= 0);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!Rst) begin
            chk("level", level, occ_after);
            if (Wren) begin
                if (exp_dq.size() == 0) chk("sb_underrun", exp_dq.size(), 1);
                else chk("data_in", data_in, exp_dq.pop_front());
            end
        end
    end

    task automatic launch(input logic [1:0] s, input logic [15:0] n);
        start    = 1'b1;
        seq_sel  = s;
        op_count = n;
        for (int k = 0; k < int'(n); k++) begin
            exp_dq.push_back(m_lfsr[DW-1:0]);
            m_lfsr = lfsr_step(m_lfsr);
        end
    endtask

    task automatic run_log(input int budget, input int pulse_at,
                           input int fw_at, input int cap_at);
        logic f_prev;
        int   lvl_prev;
        logic seen;
        f_prev   = 1'b0;
        lvl_prev = 0;
        seen     = 1'b0;
        lmax     = 0;
        log_q.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (f_prev) begin
                chk("bp_wren", Wren, 0);
                chk("bp_rden", Rden, lvl_prev != 0);
            end
            if (done) begin
                d_ops      = ops_issued;
                d_lvl      = level;
                seen       = 1'b1;
                force_full = 1'b0;
                start      = 1'b0;
                break;
            end
            log_q.push_back({Rden, Wren});
            if (int'(level) > lmax) lmax = int'(level);
            if (i == cap_at) cap_ops = ops_issued;
            start = (i == pulse_at);
            if (i == pulse_at) begin
                op_count = 16'd3;
                seq_sel  = 2'b11;
            end
            f_prev     = (fw_at >= 0) && (i >= fw_at) && (i < fw_at + 3);
            force_full = f_prev;
            lvl_prev   = int'(level);
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic cmp_log(input string tag);
        int bad;
        bad = 0;
        chk("log_len", log_q.size(), exp_q.size());
        for (int k = 0; k < log_q.size() && k < exp_q.size(); k++)
            if (log_q[k] !== exp_q[k]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic finish_run(input logic [15:0] n);
        chk("done_ops", d_ops, n);
        chk("done_level", d_lvl, 0);
        @(negedge CLK);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic exp_alt7();
        exp_q.delete();
        exp_q.push_back(2'd0);
        repeat (3) begin
            exp_q.push_back(2'd1);
            exp_q.push_back(2'd2);
        end
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
    endtask

    initial begin
        #2;
        chk("rst_wren", Wren, 0);
        chk("rst_rden", Rden, 0);
        chk("rst_data", data_in, 0);
        chk("rst_level", level, 0);
        chk("rst_ops", ops_issued, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge CLK);
        Rst = 1'b0;
        @(negedge CLK);

        launch(2'b00, 16'd128);
        run_log(400, -1, -1, -1);
        exp_q.delete();
        exp_q.push_back(2'd0);
        repeat (64) exp_q.push_back(2'd1);
        repeat (64) exp_q.push_back(2'd2);
        cmp_log("fill_drain_log");
        chk("fill_drain_peak", lmax, 64);
        finish_run(16'd128);

        launch(2'b01, 16'd7);
        run_log(50, -1, -1, -1);
        exp_alt7();
        cmp_log("alt_log");
        finish_run(16'd7);

        launch(2'b11, 16'd10);
        run_log(50, -1, -1, -1);
        exp_q.delete();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        repeat (9) exp_q.push_back(2'd3);
        exp_q.push_back(2'd2);
        cmp_log("simul_log");
        chk("simul_peak", lmax, 1);
        finish_run(16'd10);

        launch(2'b10, 16'd0);
        @(negedge CLK);
        start = 1'b0;
        chk("zero_busy", busy, 1);
        chk("zero_wren", Wren, 0);
        run_log(10, -1, -1, -1);
        exp_q.delete();
        cmp_log("zero_log");
        finish_run(16'd0);

        launch(2'b01, 16'd7);
        run_log(50, 3, -1, -1);
        exp_alt7();
        cmp_log("restart_ignored_log");
        finish_run(16'd7);

        cap_ops = 16'hFFFF;
        launch(2'b10, 16'd20);
        run_log(200, -1, 0, 3);
        chk("bp_ops_blocked", cap_ops, 0);
        chk("bp_err", err, ERR_EXP);
        finish_run(16'd20);

        launch(2'b10, 16'd24);
        run_log(200, -1, 6, -1);
        finish_run(16'd24);

        launch(2'b00, 16'd100);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (level == LW'(5)) break;
        end
        chk("rst_mid_level5", level, 5);
        Rst = 1'b1;
        exp_dq.delete();
        m_lfsr = SEED;
        #1;
        chk("rst_mid_wren", Wren, 0);
        chk("rst_mid_rden", Rden, 0);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ops", ops_issued, 0);
        @(negedge CLK);
        Rst = 1'b0;
        @(negedge CLK);
        launch(2'b01, 16'd3);
        @(negedge CLK);
        start = 1'b0;
        chk("restart_busy", busy, 1);
        @(negedge CLK);
        chk("restart_wren", Wren, 1);
        chk("restart_seed", data_in, seed_v[DW-1:0]);
        run_log(50, -1, -1, -1);
        finish_run(16'd3);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifolifo_driver.md
Name: fifolifo_driver

Overview:
Single-clock stimulus generator that drives the write/read side of the FIFO/LIFO under test: Wren, Rden and data_in.
- Produces pseudo-random data from an LFSR.
- Tracks its own expected occupancy and never overflows or underflows the DUT.
- Runs one of four sequences for a programmed number of operations, then drains the DUT to empty.

Parameters:
DEPTH, 64, DUT capacity in entries (power of two, >=2)
dat_width, 32, data bus width, legal range 1..32
SEED, 32'hACE10001, LFSR reset value, must be nonzero

Ports:
CLK  in  1  clock, rising edge
Rst  in  1  asynchronous active-high reset
start  in  1  launch sequence; sampled only in IDLE
op_count  in  16  number of issue cycles to run before draining
seq_sel  in  2  00 fill-drain, 01 alternating, 10 random, 11 simultaneous
Full  in  1  DUT full flag
Empty  in  1  DUT empty flag
Wren  out  1  write strobe to DUT
Rden  out  1  read strobe to DUT
data_in  out  dat_width  write data to DUT, valid when Wren=1
level  out  $clog2(DEPTH)+1  expected DUT occupancy
ops_issued  out  16  issue cycles completed in the current run
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of run
err  out  1  sticky flag-mismatch indicator (see Optional Feature)

Behaviour:
- Interface: CLK is the only clock. Rst is asynchronous, active-high.
- Reset values: all outputs registered and 0; LFSR=SEED; state IDLE. Rst asserted mid-run aborts at once: strobes drop, level=0, ops_issued=0.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances only on cycles with Wren=1.
  - data_in = LFSR[dat_width-1:0], presented in the same cycle as Wren.
- Guards, evaluated each cycle before driving:
  - Write allowed iff level<DEPTH and Full=0.
  - Read allowed iff level>0 and Empty=0.
  - A blocked op gives a no-strobe cycle, which is not counted.
- Level update: write only +1; read only -1; both 0; neither 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches op_count and seq_sel and clears ops_issued. Goes to RUN, or to DRAIN when op_count=0.
  - RUN: each cycle with at least one strobe increments ops_issued by 1. When ops_issued reaches op_count after the increment, go to DRAIN; no further RUN strobes.
  - DRAIN: Rden=1 each cycle while read is allowed. When level=0, go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE. level holds 0.
- Sequences in RUN:
  - 00 fill-drain: write until level=DEPTH, then read until level=0, repeat. Direction latch resets to write at start.
  - 01 alternating: write, read, write, ... The toggle advances only when the op issues.
  - 10 random: LFSR bit0=1 selects write, 0 selects read. If the selected op is blocked, issue the other if allowed.
  - 11 simultaneous: Wren and Rden both high when level>0. When level=0, write only.
- start while busy is ignored. Latency: first strobe appears 1 cycle after start is sampled.
- ops_issued saturates at 16'hFFFF.

Optional Feature:
FIFOLIFO_DRV_ERRCHK_EN
- Defined: err sets and holds until Rst when, in any cycle with busy=1, either condition holds:
  - Full=1 while level<DEPTH;
  - Empty differs from (level==0), sampled one cycle after the last level change.
- Not defined: err is tied to 0 and the checking logic is absent.

Test Plan:
- Reset mid-run: Rst pulsed in RUN with level=5 -> same-cycle Wren=0, Rden=0, level=0, busy=0; first write after restart carries data_in=SEED[dat_width-1:0].
- Fill-drain: seq_sel=00, op_count=128, DEPTH=64 -> 64 consecutive Wren, then 64 consecutive Rden; level peaks at 64; done pulses with ops_issued=128, level=0.
- Alternating with drain: seq_sel=01, op_count=7 -> pattern W,R,W,R,W,R,W; DRAIN issues 1 Rden; done 1 cycle later.
- Simultaneous: seq_sel=11, op_count=10 -> cycle 1 Wren only, cycles 2..10 Wren=Rden=1; level stays 1, then drains to 0.
- Back-pressure: seq_sel=10, Full forced 1 for 3 cycles -> no Wren in those cycles, reads issued if level>0; ops_issued counts only strobe cycles; err=1 if FIFOLIFO_DRV_ERRCHK_EN is defined and level<DEPTH.
- Zero count and start while busy: op_count=0 -> busy then done with no strobes; start re-pulsed during RUN -> ignored, ops_issued unaffected.
